// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side VGA timing checker and pixel regenerator.
// Samples the sync/colour wires on the pixel clock and rebuilds (x, y, rgb).
// It verifies line length, frame length and sync widths, and locks after a
// run of clean frames.
// Optional feature: define VGA_MON_CRC_EN to enable the per-frame signature.
module vga_timing_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk_0,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        red,
  input  logic        green,
  input  logic        blue,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [2:0]  rgb_out,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc,
  output logic        crc_valid
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_SYNC - 1);
  localparam logic [9:0] H_START     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END       = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
  localparam logic [9:0] V_START     = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END       = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] CNT_MAX     = 10'd1023;
  localparam logic [9:0] CNT_PRE_MAX = 10'd1022;
  localparam logic [3:0] LOCK_LAST   = 4'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

  state_t     state;
  logic [3:0] good;

  // Input stage and one-cycle history for edge detection
  logic       hs_q, vs_q, hs_d, vs_d;
  logic [2:0] rgb_q;

  // Timing counters and per-line / per-frame bookkeeping
  logic [9:0] h_cnt, v_cnt;
  logic       v_pend, line_first, frame_first, frame_err;

  // Combinational view of the current registered sample
  logic       hs_fall, hs_rise, vs_fall, vs_rise;
  logic [9:0] h_pos;
  logic       frame_close, active, err_any, pix_ok;
  logic       line_err, width_err, tmo_err, frame_len_err, vwidth_err;

  assign hs_fall = hs_d & ~hs_q;
  assign hs_rise = ~hs_d & hs_q;
  assign vs_fall = vs_d & ~vs_q;
  assign vs_rise = ~vs_d & vs_q;

  // h_pos is the horizontal position of the sample now in the input register
  // (the value h_cnt takes next), so the active window lines up with rgb_q.
  assign h_pos = hs_fall ? 10'd0 : ((h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1);

  // A frame closes at the first line start after v_sync fell (same cycle allowed).
  assign frame_close = hs_fall & (v_pend | vs_fall);

  assign line_err      = hs_fall & ~line_first & (h_cnt != H_LAST);
  assign width_err     = hs_rise & (h_cnt != H_SYNC_LAST);
  assign tmo_err       = ~hs_fall & (h_cnt == CNT_PRE_MAX);
  assign frame_len_err = frame_close & ~frame_first & (v_cnt != V_LAST);
  assign vwidth_err    = vs_rise & (v_cnt != V_SYNC_LAST);
  assign err_any       = line_err | width_err | tmo_err | frame_len_err | vwidth_err;

  assign active = (h_pos >= H_START) && (h_pos < H_END) &&
                  (v_cnt >= V_START) && (v_cnt < V_END);

  // Valid pixels are suppressed in the cycle an error is seen
  assign pix_ok = (state == LOCKED) & active & ~err_any;

  // Register the pins once and keep the previous sample for edge detection
  always_ff @(posedge clk_0) begin
    if (rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      rgb_q <= 3'd0;
    end else begin
      hs_q  <= h_sync;
      vs_q  <= v_sync;
      hs_d  <= hs_q;
      vs_d  <= vs_q;
      rgb_q <= {red, green, blue};
    end
  end

  // Horizontal/vertical counters, pending frame flag and check exemptions
  always_ff @(posedge clk_0) begin
    if (rst) begin
      h_cnt       <= 10'd0;
      v_cnt       <= 10'd0;
      v_pend      <= 1'b0;
      line_first  <= 1'b1;
      frame_first <= 1'b1;
      frame_err   <= 1'b0;
    end else begin
      h_cnt <= h_pos;
      if (frame_close) begin
        v_cnt <= 10'd0;
      end else if (hs_fall && (v_cnt != CNT_MAX)) begin
        v_cnt <= v_cnt + 10'd1;
      end
      if (frame_close) begin
        v_pend <= 1'b0;
      end else if (vs_fall) begin
        v_pend <= 1'b1;
      end
      // While searching, the next line/frame boundary is treated as the first one
      if (hs_fall) begin
        line_first <= 1'b0;
      end else if (state == SEARCH) begin
        line_first <= 1'b1;
      end
      if (frame_close) begin
        frame_first <= 1'b0;
      end else if (state == SEARCH) begin
        frame_first <= 1'b1;
      end
      frame_err <= frame_close ? 1'b0 : (frame_err | err_any);
    end
  end

  // Lock FSM plus all registered status and pixel outputs
  always_ff @(posedge clk_0) begin
    if (rst) begin
      state       <= SEARCH;
      good        <= 4'd0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= 8'd0;
      pixel_valid <= 1'b0;
      pixel_x     <= 10'd0;
      pixel_y     <= 10'd0;
      rgb_out     <= 3'd0;
      frame_start <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          locked <= 1'b0;
          if (vs_fall) begin
            state <= TRACK;
            good  <= 4'd0;
          end
        end
        TRACK: begin
          if (err_any) begin
            good <= 4'd0;
          end else if (frame_close && !frame_first) begin
            if (frame_err) begin
              good <= 4'd0;
            end else if (good == LOCK_LAST) begin
              state  <= LOCKED;
              good   <= 4'd0;
              locked <= 1'b1;
            end else begin
              good <= good + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (err_any) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          good   <= 4'd0;
          locked <= 1'b0;
        end
      endcase

      sync_err <= err_any & (state != SEARCH);
      if (err_any && (state != SEARCH) && (err_count != 8'd255)) begin
        err_count <= err_count + 8'd1;
      end

      pixel_valid <= pix_ok;
      pixel_x     <= pix_ok ? (h_pos - H_START) : 10'd0;
      pixel_y     <= pix_ok ? (v_cnt - V_START) : 10'd0;
      rgb_out     <= pix_ok ? rgb_q : 3'd0;
      frame_start <= (state == LOCKED) & vs_fall;
    end
  end

`ifdef VGA_MON_CRC_EN
  logic [15:0] sig;

  // One signature step: rotate left by one and fold in the pixel colour
  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [2:0] c);
    sig_step = {s[14:0], s[15]} ^ {13'd0, c};
  endfunction

  // Accumulate the frame signature over valid pixels; publish it at frame start
  always_ff @(posedge clk_0) begin
    if (rst) begin
      sig       <= 16'd0;
      frame_crc <= 16'd0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= 1'b0;
      if ((state == LOCKED) && vs_fall) begin
        frame_crc <= sig;
        crc_valid <= 1'b1;
        sig       <= 16'd0;
      end else if (pix_ok) begin
        sig <= sig_step(sig, rgb_q);
      end
    end
  end
`else
  assign frame_crc = 16'd0;
  assign crc_valid = 1'b0;
`endif

endmodule
